// File: rtl/myo_sched_pkg.sv
// Shared types for the myocontrol SPI bus scheduler: FSM state encoding and
// width helpers used by the scheduler and its next-unit finder.
package myo_sched_pkg;

  localparam int unsigned NUM_MOTORS_DFLT = 7;
  localparam int unsigned IDX_W = $clog2(NUM_MOTORS_DFLT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } sched_state_e;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/myo_next_unit.sv
// Combinational finder: lowest set mask bit strictly above cur_idx, or the
// lowest set bit overall when first is high.
module myo_next_unit
  import myo_sched_pkg::*;
#(
  parameter int unsigned NUM_MOTORS = NUM_MOTORS_DFLT,
  parameter int unsigned IW         = IDX_W
) (
  input  logic [NUM_MOTORS-1:0] mask,
  input  logic [IW-1:0]         cur_idx,
  input  logic                  first,
  output logic                  found,
  output logic [IW-1:0]         idx
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur_idx)))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/myo_spi_scheduler.sv
// Sweeps enabled motor units on the shared SPI bus once per update period:
// select, setup delay, start pulse, wait for completion, inter-frame gap.
module myo_spi_scheduler
  import myo_sched_pkg::*;
#(
  parameter int unsigned NUM_MOTORS     = 7,
  parameter int unsigned PERIOD_W       = 32,
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned IW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  power_sense_n,
  input  logic [NUM_MOTORS-1:0] motor_mask,
  input  logic [PERIOD_W-1:0]   update_period,
  input  logic                  err_clr,
  input  logic                  spi_done,
  output logic                  spi_start,
  output logic [NUM_MOTORS-1:0] ss_n,
  output logic [IW-1:0]         motor_idx,
  output logic                  sweep_done,
  output logic                  overrun_err,
  output logic                  timeout_err,
  output logic [IW-1:0]         timeout_idx
);

  localparam int unsigned TMAX_A = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int unsigned TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
  localparam int unsigned TW     = cnt_w(TMAX);
  localparam logic [TW-1:0] SETUP_LD   = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD     = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYCLES - 1);

  logic                  run;
  logic                  tick;
  logic [PERIOD_W-1:0]   per_cnt_d, per_cnt_q;

  sched_state_e          state_q;
  logic [TW-1:0]         timer_q;
  logic [NUM_MOTORS-1:0] mask_q;
  logic [NUM_MOTORS-1:0] ss_n_q;
  logic [NUM_MOTORS-1:0] sel_oh;
  logic [IW-1:0]         idx_q, timeout_idx_q;
  logic                  first_q, abort_q;
  logic                  spi_start_q, sweep_done_q, overrun_q, timeout_q;
  logic                  nu_found;
  logic [IW-1:0]         nu_idx;

  assign run = enable & ~power_sense_n;

  always_comb begin
    tick      = 1'b0;
    per_cnt_d = '0;
    if (run) begin
      if ((update_period == '0) || (per_cnt_q == update_period - PERIOD_W'(1))) begin
        tick = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) per_cnt_q <= '0;
    else          per_cnt_q <= per_cnt_d;
  end

  myo_next_unit #(
    .NUM_MOTORS (NUM_MOTORS),
    .IW         (IW)
  ) u_next_unit (
    .mask    (mask_q),
    .cur_idx (idx_q),
    .first   (first_q),
    .found   (nu_found),
    .idx     (nu_idx)
  );

  assign sel_oh = {{(NUM_MOTORS-1){1'b0}}, 1'b1} << nu_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      mask_q        <= '0;
      ss_n_q        <= '1;
      idx_q         <= '0;
      timeout_idx_q <= '0;
      first_q       <= 1'b0;
      abort_q       <= 1'b0;
      spi_start_q   <= 1'b0;
      sweep_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      spi_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      overrun_q    <= (tick && (state_q != ST_IDLE)) | (overrun_q & ~err_clr);
      timeout_q    <= timeout_q & ~err_clr;
      // Losing run mid-sweep lets the current frame finish, then parks in IDLE.
      if ((state_q != ST_IDLE) && !run) abort_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (tick) begin
            mask_q  <= motor_mask;
            first_q <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (abort_q || !run) begin
            state_q <= ST_IDLE;
          end else if (nu_found) begin
            idx_q   <= nu_idx;
            first_q <= 1'b0;
            ss_n_q  <= ~sel_oh;
            timer_q <= SETUP_LD;
            state_q <= ST_SETUP;
          end else begin
            sweep_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_SETUP: begin
          if (timer_q == '0) begin
            spi_start_q <= 1'b1;
            state_q     <= ST_START;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_START: begin
          timer_q <= TIMEOUT_LD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done) begin
            ss_n_q  <= '1;
            timer_q <= GAP_LD;
            state_q <= ST_GAP;
          end else if (timer_q == '0) begin
            timeout_q     <= 1'b1;
            timeout_idx_q <= idx_q;
            ss_n_q        <= '1;
            timer_q       <= GAP_LD;
            state_q       <= ST_GAP;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (timer_q == '0) begin
            state_q <= (abort_q || !run) ? ST_IDLE : ST_SELECT;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_start   = spi_start_q;
  assign ss_n        = ss_n_q;
  assign motor_idx   = idx_q;
  assign sweep_done  = sweep_done_q;
  assign overrun_err = overrun_q;
  assign timeout_err = timeout_q;
  assign timeout_idx = timeout_idx_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Directed bench for the SPI bus scheduler with a simple spi_done responder
// and a negedge monitor that counts frames, sweeps and select activity.
module tb_myo_spi_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        power_sense_n = 1'b1;
  logic [6:0]  motor_mask = '0;
  logic [31:0] update_period = '0;
  logic        err_clr = 1'b0;
  logic        spi_done = 1'b0;
  logic        spi_start;
  logic [6:0]  ss_n;
  logic [2:0]  motor_idx;
  logic        sweep_done;
  logic        overrun_err;
  logic        timeout_err;
  logic [2:0]  timeout_idx;

  int n_chk = 0;
  int n_fail = 0;

  logic resp_en = 1'b0;
  int   resp_dly = 20;

  int cyc = 0;
  int n_start = 0;
  int n_sweep = 0;
  int n_multi = 0;
  int low_cnt [7];
  logic [6:0] ss_prev = 7'h7F;

  int c0, s_start, s_sweep;
  int s_low [7];

  myo_spi_scheduler u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .power_sense_n (power_sense_n),
    .motor_mask    (motor_mask),
    .update_period (update_period),
    .err_clr       (err_clr),
    .spi_done      (spi_done),
    .spi_start     (spi_start),
    .ss_n          (ss_n),
    .motor_idx     (motor_idx),
    .sweep_done    (sweep_done),
    .overrun_err   (overrun_err),
    .timeout_err   (timeout_err),
    .timeout_idx   (timeout_idx)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 7; i++) low_cnt[i] = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (spi_start) n_start++;
      if (sweep_done) n_sweep++;
      if ($countones(~ss_n) > 1) n_multi++;
      for (int i = 0; i < 7; i++) if (ss_prev[i] && !ss_n[i]) low_cnt[i]++;
      ss_prev = ss_n;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (resp_en && spi_start) begin
        repeat (resp_dly) @(negedge clock);
        spi_done = 1'b1;
        @(negedge clock);
        spi_done = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic snap();
    c0 = cyc;
    s_start = n_start;
    s_sweep = n_sweep;
    for (int i = 0; i < 7; i++) s_low[i] = low_cnt[i];
  endtask

  task automatic step_to(input int k);
    while (cyc < c0 + k) step();
  endtask

  task automatic wait_ss(input string tag, input logic [6:0] val, input int lim);
    int k;
    k = 0;
    while (ss_n !== val && k < lim) begin
      step();
      k++;
    end
    check_eq(tag, 32'(ss_n), 32'(val));
  endtask

  initial begin
    step(); step(); step();
    check_eq("rst_ss_n", 32'(ss_n), 32'h7F);
    check_eq("rst_spi_start", 32'(spi_start), 32'h0);
    check_eq("rst_sweep_done", 32'(sweep_done), 32'h0);
    check_eq("rst_motor_idx", 32'(motor_idx), 32'h0);
    check_eq("rst_overrun", 32'(overrun_err), 32'h0);
    check_eq("rst_timeout", 32'(timeout_err), 32'h0);
    reset_n = 1'b1;
    power_sense_n = 1'b0;
    step(); step();

    // Two-unit sweep, period 1000, frames answered after 20 clocks
    motor_mask = 7'b0000101; update_period = 1000; resp_dly = 20; resp_en = 1'b1;
    snap(); enable = 1'b1;
    wait_ss("t1_first_sel", 7'h7E, 1100);
    check_eq("t1_idx0", 32'(motor_idx), 32'd0);
    step(); step(); step();
    check_eq("t1_setup_no_start", 32'(spi_start), 32'h0);
    step();
    check_eq("t1_start_after_setup", 32'(spi_start), 32'h1);
    wait_ss("t1_second_sel", 7'h7B, 200);
    check_eq("t1_idx2", 32'(motor_idx), 32'd2);
    step_to(3500);
    check_eq("t1_sweeps", 32'(n_sweep - s_sweep), 32'd3);
    check_eq("t1_starts", 32'(n_start - s_start), 32'd6);
    check_eq("t1_sel0", 32'(low_cnt[0] - s_low[0]), 32'd3);
    check_eq("t1_sel2", 32'(low_cnt[2] - s_low[2]), 32'd3);
    check_eq("t1_sel1", 32'(low_cnt[1] - s_low[1]), 32'd0);
    check_eq("t1_overrun", 32'(overrun_err), 32'h0);
    check_eq("t1_timeout", 32'(timeout_err), 32'h0);
    enable = 1'b0; step(); step();

    // Empty mask: sweeps complete with no bus activity
    motor_mask = 7'b0; update_period = 100;
    snap(); enable = 1'b1;
    step_to(1050);
    check_eq("t2_sweeps", 32'(n_sweep - s_sweep), 32'd10);
    check_eq("t2_starts", 32'(n_start - s_start), 32'd0);
    check_eq("t2_sel_any", 32'((low_cnt[0]-s_low[0]) + (low_cnt[3]-s_low[3]) + (low_cnt[6]-s_low[6])), 32'd0);
    check_eq("t2_ss_n", 32'(ss_n), 32'h7F);
    check_eq("t2_overrun", 32'(overrun_err), 32'h0);
    enable = 1'b0; step(); step();

    // Unanswered frame on unit 3 times out after 4096 clocks in WAIT
    resp_en = 1'b0; motor_mask = 7'b0001000; update_period = 5;
    snap(); enable = 1'b1;
    wait_ss("t3_sel3", 7'h77, 30);
    enable = 1'b0;
    repeat (4100) step();
    check_eq("t3_still_waiting", 32'(ss_n), 32'h77);
    check_eq("t3_no_timeout_yet", 32'(timeout_err), 32'h0);
    step();
    check_eq("t3_released", 32'(ss_n), 32'h7F);
    check_eq("t3_timeout_err", 32'(timeout_err), 32'h1);
    check_eq("t3_timeout_idx", 32'(timeout_idx), 32'd3);
    repeat (60) step();
    check_eq("t3_no_sweep_done", 32'(n_sweep - s_sweep), 32'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("t3_err_clr", 32'(timeout_err), 32'h0);
    step();

    // Period shorter than a sweep: overrun, with set-beats-clear
    resp_en = 1'b1; resp_dly = 200; motor_mask = 7'b0000010; update_period = 10;
    snap(); enable = 1'b1;
    step_to(29); err_clr = 1'b1;
    step_to(30); err_clr = 1'b0;
    check_eq("t4_set_wins", 32'(overrun_err), 32'h1);
    step_to(34); err_clr = 1'b1;
    step_to(35); err_clr = 1'b0;
    check_eq("t4_clr_no_tick", 32'(overrun_err), 32'h0);
    step_to(40);
    check_eq("t4_reset_by_tick", 32'(overrun_err), 32'h1);
    step_to(250);
    check_eq("t4_one_select", 32'(low_cnt[1] - s_low[1]), 32'd1);
    check_eq("t4_one_start", 32'(n_start - s_start), 32'd1);
    check_eq("t4_no_sweep_yet", 32'(n_sweep - s_sweep), 32'd0);
    enable = 1'b0;
    repeat (300) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("t4_overrun_clr", 32'(overrun_err), 32'h0);

    // Enable drops mid-frame: frame completes, no sweep_done
    resp_dly = 30; update_period = 50;
    snap(); enable = 1'b1;
    wait_ss("t5_sel1", 7'h7D, 100);
    repeat (6) step();
    enable = 1'b0;
    repeat (10) step();
    check_eq("t5_frame_held", 32'(ss_n), 32'h7D);
    repeat (150) step();
    check_eq("t5_released", 32'(ss_n), 32'h7F);
    check_eq("t5_one_start", 32'(n_start - s_start), 32'd1);
    check_eq("t5_no_sweep_done", 32'(n_sweep - s_sweep), 32'd0);
    snap(); power_sense_n = 1'b1; enable = 1'b1;
    repeat (200) step();
    check_eq("t5_pwr_no_sel", 32'(low_cnt[1] - s_low[1]), 32'd0);
    check_eq("t5_pwr_no_sweep", 32'(n_sweep - s_sweep), 32'd0);
    enable = 1'b0; power_sense_n = 1'b0; step(); step();

    // Asynchronous reset while a frame is waiting
    resp_en = 1'b0; motor_mask = 7'b0000001; update_period = 20;
    snap(); enable = 1'b1;
    wait_ss("t6_sel0", 7'h7E, 40);
    repeat (6) step();
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_async_ss_n", 32'(ss_n), 32'h7F);
    check_eq("t6_timeout_idx", 32'(timeout_idx), 32'd0);
    check_eq("t6_flags", 32'({spi_start, sweep_done, overrun_err, timeout_err}), 32'h0);
    enable = 1'b0;
    step(); reset_n = 1'b1; step();

    check_eq("one_hot_select", 32'(n_multi), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
